// File: rtl/pc_sequencer_if.sv
// Bus between the sequencer, the program counter/memory and the timer datapath.
interface pc_sequencer_if;
  logic [7:0]  PCvalue;
  logic [11:0] InstrIn;
  logic        ZeroFlag;
  logic        load;
  logic        inc;
  logic [7:0]  LoadVal;
  logic [7:0]  PortOut;
  logic        halted;

  modport master (
    input  PCvalue, InstrIn, ZeroFlag,
    output load, inc, LoadVal, PortOut, halted
  );

  modport slave (
    output PCvalue, InstrIn, ZeroFlag,
    input  load, inc, LoadVal, PortOut, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute controller driving PC load/inc, with timed WAIT and OUT port.
// Optional CALL/RET (one-level return register) under macro PC_SEQUENCER_CALL_EN.
module pc_sequencer #(
  parameter int WAIT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;

  state_t              r_state, w_next;
  logic [WAIT_W-1:0]   r_cnt;
  logic [7:0]          r_port;
  logic                w_load, w_inc, w_out_en, w_cnt_load;
  logic [7:0]          w_lv;
  logic [3:0]          w_op;
  logic [7:0]          w_arg;
`ifdef PC_SEQUENCER_CALL_EN
  logic [7:0]          r_ret;
  logic                w_call;
`endif

  assign w_op  = bus.InstrIn[11:8];
  assign w_arg = bus.InstrIn[7:0];

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_inc      = 1'b0;
    w_lv       = 8'h00;
    w_out_en   = 1'b0;
    w_cnt_load = 1'b0;
`ifdef PC_SEQUENCER_CALL_EN
    w_call     = 1'b0;
`endif
    case (r_state)
      S_FETCH: w_next = S_EXEC;
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_op)
          4'h1: begin w_load = 1'b1; w_lv = w_arg; end
          4'h2: if (bus.ZeroFlag)  begin w_load = 1'b1; w_lv = w_arg; end
                else w_inc = 1'b1;
          4'h3: if (!bus.ZeroFlag) begin w_load = 1'b1; w_lv = w_arg; end
                else w_inc = 1'b1;
          4'h4: if (w_arg != 8'h00) begin
                  w_cnt_load = 1'b1;
                  w_next     = S_WAIT;
                end else w_inc = 1'b1;
          4'h5: begin w_out_en = 1'b1; w_inc = 1'b1; end
`ifdef PC_SEQUENCER_CALL_EN
          4'h6: begin w_call = 1'b1; w_load = 1'b1; w_lv = w_arg; end
          4'h7: begin w_load = 1'b1; w_lv = r_ret; end
`endif
          4'hF: w_next = S_HALT;
          default: w_inc = 1'b1;
        endcase
      end
      S_WAIT: if (r_cnt == '0) begin
        w_inc  = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_HALT;
    endcase
  end

  // Counter holds n-1 on entry so that WAIT n spends exactly n cycles in S_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_port  <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_cnt_load)
        r_cnt <= WAIT_W'(w_arg) - WAIT_W'(1);
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - WAIT_W'(1);
      if (w_out_en)
        r_port <= w_arg;
    end
  end

`ifdef PC_SEQUENCER_CALL_EN
  always_ff @(posedge clk) begin
    if (reset)       r_ret <= 8'h00;
    else if (w_call) r_ret <= bus.PCvalue + 8'd1;
  end
`endif

  assign bus.load    = w_load;
  assign bus.inc     = w_inc;
  assign bus.LoadVal = w_lv;
  assign bus.PortOut = r_port;
  assign bus.halted  = (r_state == S_HALT);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench: driver pushes per-cycle expectations, negedge monitor checks.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  pc_sequencer_if bus();

  pc_sequencer #(.WAIT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef PC_SEQUENCER_CALL_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       ld;
    logic       in;
    logic [7:0] lv;
    logic [7:0] po;
    logic       h;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // One cycle: inputs applied just after the edge, expectation queued for this cycle.
  task automatic v(input string nm, input logic rst, input logic [7:0] pc,
                   input logic [11:0] ins, input logic zf, input logic el,
                   input logic ei, input logic [7:0] elv, input logic [7:0] ep,
                   input logic eh);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    bus.PCvalue  = pc;
    bus.InstrIn  = ins;
    bus.ZeroFlag = zf;
    e.name = nm; e.ld = el; e.in = ei; e.lv = elv; e.po = ep; e.h = eh;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (bus.load !== e.ld || bus.inc !== e.in || bus.LoadVal !== e.lv ||
          bus.PortOut !== e.po || bus.halted !== e.h) begin
        n_bad++;
        $display("FAIL %s: got load=%0b inc=%0b LoadVal=%h PortOut=%h halted=%0b, want load=%0b inc=%0b LoadVal=%h PortOut=%h halted=%0b",
                 e.name, bus.load, bus.inc, bus.LoadVal, bus.PortOut, bus.halted,
                 e.ld, e.in, e.lv, e.po, e.h);
      end
    end
  end

  initial begin
    bus.PCvalue  = 8'h00;
    bus.InstrIn  = 12'h1AB;
    bus.ZeroFlag = 1'b1;

    v("rst0", 1, 8'h00, 12'h1AB, 1, 0, 0, 8'h00, 8'h00, 0);
    v("rst1", 1, 8'h00, 12'h1AB, 1, 0, 0, 8'h00, 8'h00, 0);

    v("nop_f", 0, 8'h05, 12'h000, 0, 0, 0, 8'h00, 8'h00, 0);
    v("nop_x", 0, 8'h05, 12'h000, 0, 0, 1, 8'h00, 8'h00, 0);
    v("jmp_f", 0, 8'h06, 12'h191, 0, 0, 0, 8'h00, 8'h00, 0);
    v("jmp_x", 0, 8'h06, 12'h191, 0, 1, 0, 8'h91, 8'h00, 0);

    v("jz1_f", 0, 8'h10, 12'h240, 1, 0, 0, 8'h00, 8'h00, 0);
    v("jz1_x", 0, 8'h10, 12'h240, 1, 1, 0, 8'h40, 8'h00, 0);
    v("jz0_f", 0, 8'h10, 12'h240, 0, 0, 0, 8'h00, 8'h00, 0);
    v("jz0_x", 0, 8'h10, 12'h240, 0, 0, 1, 8'h00, 8'h00, 0);
    v("jzt_f", 0, 8'h10, 12'h240, 0, 0, 0, 8'h00, 8'h00, 0);
    v("jzt_x", 0, 8'h10, 12'h240, 1, 1, 0, 8'h40, 8'h00, 0);
    v("jnz0_f", 0, 8'h10, 12'h340, 1, 0, 0, 8'h00, 8'h00, 0);
    v("jnz0_x", 0, 8'h10, 12'h340, 0, 1, 0, 8'h40, 8'h00, 0);
    v("jnz1_f", 0, 8'h10, 12'h340, 0, 0, 0, 8'h00, 8'h00, 0);
    v("jnz1_x", 0, 8'h10, 12'h340, 1, 0, 1, 8'h00, 8'h00, 0);
    v("jnzt_f", 0, 8'h10, 12'h340, 0, 0, 0, 8'h00, 8'h00, 0);
    v("jnzt_x", 0, 8'h10, 12'h340, 1, 0, 1, 8'h00, 8'h00, 0);

    v("w3_f",  0, 8'h11, 12'h403, 0, 0, 0, 8'h00, 8'h00, 0);
    v("w3_x",  0, 8'h11, 12'h403, 0, 0, 0, 8'h00, 8'h00, 0);
    v("w3_w2", 0, 8'h11, 12'h403, 1, 0, 0, 8'h00, 8'h00, 0);
    v("w3_w1", 0, 8'h11, 12'h403, 0, 0, 0, 8'h00, 8'h00, 0);
    v("w3_w0", 0, 8'h11, 12'h403, 1, 0, 1, 8'h00, 8'h00, 0);
    v("w0_f",  0, 8'h12, 12'h400, 0, 0, 0, 8'h00, 8'h00, 0);
    v("w0_x",  0, 8'h12, 12'h400, 0, 0, 1, 8'h00, 8'h00, 0);

    v("out_f", 0, 8'h13, 12'h55A, 0, 0, 0, 8'h00, 8'h00, 0);
    v("out_x", 0, 8'h13, 12'h55A, 0, 0, 1, 8'h00, 8'h00, 0);

    v("call_f", 0, 8'hFF, 12'h620, 0, 0, 0, 8'h00, 8'h5A, 0);
    v("call_x", 0, 8'hFF, 12'h620, 0, CE, !CE, CE ? 8'h20 : 8'h00, 8'h5A, 0);
    v("ret_f",  0, 8'h20, 12'h700, 0, 0, 0, 8'h00, 8'h5A, 0);
    v("ret_x",  0, 8'h20, 12'h700, 0, CE, !CE, 8'h00, 8'h5A, 0);
    v("c1_f",   0, 8'h30, 12'h650, 0, 0, 0, 8'h00, 8'h5A, 0);
    v("c1_x",   0, 8'h30, 12'h650, 0, CE, !CE, CE ? 8'h50 : 8'h00, 8'h5A, 0);
    v("c2_f",   0, 8'h40, 12'h660, 0, 0, 0, 8'h00, 8'h5A, 0);
    v("c2_x",   0, 8'h40, 12'h660, 0, CE, !CE, CE ? 8'h60 : 8'h00, 8'h5A, 0);
    v("r2_f",   0, 8'h60, 12'h700, 0, 0, 0, 8'h00, 8'h5A, 0);
    v("r2_x",   0, 8'h60, 12'h700, 0, CE, !CE, CE ? 8'h41 : 8'h00, 8'h5A, 0);

    v("unk_f", 0, 8'h41, 12'h8FF, 1, 0, 0, 8'h00, 8'h5A, 0);
    v("unk_x", 0, 8'h41, 12'h8FF, 1, 0, 1, 8'h00, 8'h5A, 0);

    // Reset in the middle of WAIT 200, then a short WAIT 2 starts from scratch.
    v("w200_f", 0, 8'h42, 12'h4C8, 0, 0, 0, 8'h00, 8'h5A, 0);
    v("w200_x", 0, 8'h42, 12'h4C8, 0, 0, 0, 8'h00, 8'h5A, 0);
    for (int i = 0; i < 5; i++)
      v("w200_w", 0, 8'h42, 12'h4C8, 0, 0, 0, 8'h00, 8'h5A, 0);
    v("w200_rst", 1, 8'h42, 12'h4C8, 0, 0, 0, 8'h00, 8'h5A, 0);
    v("w2_f",  0, 8'h00, 12'h402, 0, 0, 0, 8'h00, 8'h00, 0);
    v("w2_x",  0, 8'h00, 12'h402, 0, 0, 0, 8'h00, 8'h00, 0);
    v("w2_w1", 0, 8'h00, 12'h402, 0, 0, 0, 8'h00, 8'h00, 0);
    v("w2_w0", 0, 8'h00, 12'h402, 0, 0, 1, 8'h00, 8'h00, 0);

    v("halt_f", 0, 8'h01, 12'hF00, 0, 0, 0, 8'h00, 8'h00, 0);
    v("halt_x", 0, 8'h01, 12'hF00, 0, 0, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 20; i++)
      v("halted", 0, 8'h01, 12'h1AB, i[0], 0, 0, 8'h00, 8'h00, 1);
    v("halt_rst", 1, 8'h01, 12'h1AB, 1, 0, 0, 8'h00, 8'h00, 1);
    v("post_f", 0, 8'h00, 12'h000, 0, 0, 0, 8'h00, 8'h00, 0);
    v("post_x", 0, 8'h00, 12'h000, 0, 0, 1, 8'h00, 8'h00, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

- Fetch/execute controller that drives the `ProgramCounter` stage.
- Takes the current PC value as the program-memory address and receives the addressed 12-bit instruction.
- Decodes the instruction and produces the PC's `load`, `inc` and `LoadVal` controls.
- Also provides a timed-wait instruction and an 8-bit output port for the two-mode timer datapath.

## Interface

Parameters:
- WAIT_W, default 8: width of the WAIT cycle counter; the operand is zero-extended into it.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high. Clears this block; the same signal resets the PC.
- PCvalue  in  8  current PC output; used as the program-memory address and as the return-address source.
- InstrIn  in  12  program-memory read data.
  - Memory is synchronous: data is valid one cycle after the address is presented.
  - Fields: [11:8] opcode, [7:0] operand.
- ZeroFlag  in  1  condition input from the timer datapath; sampled only in EXEC.
- load  out  1  PC load strobe.
- inc  out  1  PC increment strobe.
- LoadVal  out  8  PC load value; meaningful only while `load`=1, otherwise 0.
- PortOut  out  8  registered output port.
- halted  out  1  high while in HALT.

## Operation

Opcodes (others decode as NOP):
- 0 NOP: inc.
- 1 JMP a: load a.
- 2 JZ a: if ZeroFlag, load a; else inc.
- 3 JNZ a: if !ZeroFlag, load a; else inc.
- 4 WAIT n: stall n cycles, then inc.
- 5 OUT v: PortOut<=v, inc.
- 6 CALL a: RetAddr<=PCvalue+1 (mod 256), load a. Requires the macro.
- 7 RET: load RetAddr. Requires the macro.
- F HALT: enter HALT.

State machine:
- FETCH → EXEC: unconditional; covers the memory read latency. load=inc=0.
- EXEC: decode InstrIn.
  - WAIT with n≠0: load counter with n-1, go to WAIT, no strobe.
  - WAIT with n=0: behaves as NOP.
  - HALT: go to HALT.
  - Otherwise: assert exactly one strobe, return to FETCH.
- WAIT: counter decrements each cycle. While counter≠0: no strobe. When counter=0: assert inc, go to FETCH.
- HALT: absorbing state. halted=1, load=inc=0, exits only on reset.

Output and strobe rules:
- `load` and `inc` are never high together.
- `load`, `inc` and `LoadVal` are decoded combinationally from state and the registered instruction. They are stable for the whole EXEC/WAIT cycle.
- PortOut and RetAddr are registers.

Reset:
- State=FETCH, counter=0, RetAddr=0, PortOut=0x00, halted=0, load=inc=0, LoadVal=0.
- Reset has priority over any state, including mid-WAIT and HALT.

## Timing

- NOP/JMP/JZ/JNZ/OUT/CALL/RET: 2 cycles per instruction. The PC updates on the EXEC→FETCH edge.
- WAIT n: 2+n cycles for n≥1; 2 cycles for n=0.
- OUT: PortOut updates on the same edge as the PC increment.
- PC wrap: the PC increments 0xFF→0x00. CALL at 0xFF stores RetAddr=0x00.
- ZeroFlag is sampled in the EXEC cycle only. Changes during FETCH or WAIT have no effect.
- First EXEC after reset release is cycle 2; the PC holds its reset value until then.

## Configuration

Macro: PC_SEQUENCER_CALL_EN.
- Defined: opcodes 6/7 are CALL/RET with an 8-bit RetAddr register; one level deep, and a nested CALL overwrites it.
- Undefined: RetAddr is not built; opcodes 6/7 decode as NOP (inc).

## Test plan

- Reset check: reset for 2 cycles, with InstrIn=0x1AB and ZeroFlag=1 → load=inc=0, LoadVal=0, PortOut=0x00, halted=0 throughout.
- NOP then JMP: PC=0x05, InstrIn=0x000 → inc on cycle 2. Then InstrIn=0x191 → load=1, LoadVal=0x91 in its EXEC cycle; never both strobes together.
- Conditional jumps, JZ 0x40 at PC 0x10:
  - ZeroFlag=1 → load, LoadVal=0x40.
  - ZeroFlag=0 → inc.
  - JNZ gives the inverse.
  - Toggling ZeroFlag during FETCH has no effect.
- WAIT and OUT:
  - WAIT 3 (0x403) → exactly 3 cycles with no strobe, then inc; 5 cycles total.
  - WAIT 0 → 2 cycles.
  - OUT 0x5A (0x55A) → PortOut=0x5A after the EXEC edge.
- CALL/RET (macro on): at PC=0xFF, CALL 0x20 → LoadVal=0x20; then RET → LoadVal=0x00. With the macro off, the same opcodes each produce inc.
- HALT and reset mid-WAIT:
  - HALT (0xF00) → halted=1 with no strobes for 20 cycles.
  - Reset clears halted.
  - Reset asserted mid-WAIT 200 → FETCH state, no inc, counter restarts from scratch.
